// File: rtl/bcd_score_bank.sv
// Multi-player BCD score bank: edge-detected point strobes, wrap/saturate
// ripple increment per player, and registered win/game-over detection.
module bcd_score_bank #(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2,
    parameter int WIN_SCORE   = 11,
    parameter int SAT_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PLAYERS-1:0]        inc,
    input  logic                          clr,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] score,
    output logic [NUM_PLAYERS-1:0]        score_evt,
    output logic                          game_over,
    output logic [NUM_PLAYERS-1:0]        winner
);
    localparam int W = DIGITS * 4;

    function automatic logic [W-1:0] to_bcd(input int value);
        int t;
        logic [W-1:0] r;
        t = value;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam bit           WIN_EN  = (WIN_SCORE != 0);
    localparam bit           SAT_EN  = (SAT_MODE != 0);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || DIGITS < 1 || DIGITS > 6 ||
        WIN_SCORE < 0 || WIN_SCORE >= 10**DIGITS) begin : g_bad_param
        $error("bcd_score_bank: illegal parameter combination");
    end

    logic [NUM_PLAYERS-1:0] inc_q_reg;
    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] hit;
    logic                   game_over_reg;
    logic [NUM_PLAYERS-1:0] winner_reg;

    // inc_q resets to ones so a strobe held through reset is not a new edge.
    assign rise = inc & ~inc_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_q_reg <= '1;
        end else begin
            inc_q_reg <= inc;
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [W-1:0]    digits_reg;
        logic [W-1:0]    digits_next;
        logic            evt_reg;
        logic [DIGITS:0] carry;
        logic            bump;

        always_comb begin
            digits_next = digits_reg;
            carry       = '0;
            carry[0]    = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                if (carry[d]) begin
                    digits_next[d*4 +: 4] = (digits_reg[d*4 +: 4] == 4'd9) ?
                                            4'd0 : digits_reg[d*4 +: 4] + 4'd1;
                end
                carry[d+1] = carry[d] & (digits_reg[d*4 +: 4] == 4'd9);
            end
        end

        // carry out of the top digit means the score is all 9s.
        assign bump = rise[gi] & ~game_over_reg & ~(SAT_EN & carry[DIGITS]);

        always_ff @(posedge clk) begin
            if (reset || clr) begin
                digits_reg <= '0;
                evt_reg    <= 1'b0;
            end else begin
                evt_reg <= bump;
                if (bump) begin
                    digits_reg <= digits_next;
                end
            end
        end

        assign hit[gi]               = WIN_EN && (digits_reg == WIN_BCD);
        assign score[gi*W +: W]      = digits_reg;
        assign score_evt[gi]         = evt_reg;
    end

    // Winner is latched from the registered scores, so it trails the winning point by a cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            game_over_reg <= 1'b0;
            winner_reg    <= '0;
        end else if (!game_over_reg && |hit) begin
            game_over_reg <= 1'b1;
            winner_reg    <= hit;
        end
    end

    assign game_over = game_over_reg;
    assign winner    = winner_reg;
endmodule
